// File: rtl/sdram_pkg.sv
// sdram_pkg: shared constants and types for the SDRAM arbiter slice.
//   Slot geometry (length, cs-high window, read capture point), bus widths,
//   arbiter FSM state and slot-owner encodings.
package sdram_pkg;

    localparam int unsigned SLOT_LEN     = 10;
    localparam int unsigned CS_HIGH_LAST = 3;
    localparam int unsigned CAPTURE_CNT  = 7;
    localparam int unsigned ADDR_W       = 22;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned SLOT_CNT_W   = 4;

    typedef enum logic {
        ST_IDLE,
        ST_SLOT
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_P0,
        OWN_P1,
        OWN_REF
    } owner_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundle of the two requester ports and the controller
// strobes.
//   slave  : arbiter view (takes requests and mem_dout/mem_ready, drives
//            acks, read data and the controller strobes)
//   master : requester/controller view (the opposite directions)
interface sdram_arbiter_if;
    import sdram_pkg::*;

    logic              mem_ready;

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_din;
    logic [1:0]        p0_ds;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_dout;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_din;
    logic [1:0]        p1_ds;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_dout;

    logic              mem_cs;
    logic              mem_we;
    logic              mem_refresh;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [1:0]        mem_ds;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  mem_ready,
        input  p0_req, p0_we, p0_addr, p0_din, p0_ds,
        output p0_ack, p0_dout,
        input  p1_req, p1_we, p1_addr, p1_din, p1_ds,
        output p1_ack, p1_dout,
        output mem_cs, mem_we, mem_refresh, mem_addr, mem_din, mem_ds,
        input  mem_dout
    );

    modport master (
        output mem_ready,
        output p0_req, p0_we, p0_addr, p0_din, p0_ds,
        input  p0_ack, p0_dout,
        output p1_req, p1_we, p1_addr, p1_din, p1_ds,
        input  p1_ack, p1_dout,
        input  mem_cs, mem_we, mem_refresh, mem_addr, mem_din, mem_ds,
        output mem_dout
    );

endinterface

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running refresh interval counter plus a
// saturating (0..3) count of refreshes still owed to the SDRAM.
//   clk, reset_n  : clock, asynchronous active-low reset
//   grant_refresh : a refresh slot is being granted this cycle
//   pending       : number of outstanding refreshes
module sdram_refresh_timer #(
    parameter int unsigned REFRESH_INTERVAL = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       grant_refresh,
    output logic [1:0] pending
);

    localparam int unsigned       TICK_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_INTERVAL - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        pend_q, pend_d;
    logic              wrap;

    always_comb begin
        wrap   = (tick_q == TICK_LAST);
        tick_d = wrap ? '0 : tick_q + TICK_ONE;
        pend_d = pend_q;
        // A wrap and a grant in the same cycle cancel out.
        if (wrap && !grant_refresh) begin
            if (pend_q != 2'd3) begin
                pend_d = pend_q + 2'd1;
            end
        end else if (!wrap && grant_refresh) begin
            pend_d = pend_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: merges chipset (port 0, high priority), CPU (port 1) and
// periodic refresh onto the SDRAM controller in fixed 10-clock slots.
//   clk, reset_n : 32 MHz system clock, asynchronous active-low reset
//   bus          : requester ports, controller strobes and mem_dout/mem_ready
// Within a slot cs is high for counts 0..3 and low for 4..9, so the
// controller always sees a fresh rising edge; read data is captured and the
// requester acked on the edge leaving count 7.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = 250
) (
    input  logic            clk,
    input  logic            reset_n,
    sdram_arbiter_if.slave  bus
);

    localparam logic [SLOT_CNT_W-1:0] CNT_LAST    = SLOT_CNT_W'(SLOT_LEN - 1);
    localparam logic [SLOT_CNT_W-1:0] CNT_CS_LAST = SLOT_CNT_W'(CS_HIGH_LAST);
    localparam logic [SLOT_CNT_W-1:0] CNT_CAPTURE = SLOT_CNT_W'(CAPTURE_CNT);
    localparam logic [SLOT_CNT_W-1:0] CNT_ONE     = SLOT_CNT_W'(1);

    state_e                state_q, state_d;
    logic [SLOT_CNT_W-1:0] cnt_q, cnt_d;
    owner_e                grant;
    owner_e                owner_q, owner_d;
    logic [1:0]            pending;

    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              ref_q, ref_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [1:0]        ds_q, ds_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] dout0_q, dout0_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh (
        .clk          (clk),
        .reset_n      (reset_n),
        .grant_refresh(grant == OWN_REF),
        .pending      (pending)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: grants only in IDLE or on the last slot count.
    always_comb begin
        grant = OWN_NONE;
        if (bus.mem_ready && (state_q == ST_IDLE || cnt_q == CNT_LAST)) begin
            if (pending != 2'd0) begin
                grant = OWN_REF;
            end else if (bus.p0_req) begin
                grant = OWN_P0;
            end else if (bus.p1_req) begin
                grant = OWN_P1;
            end
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        if (grant != OWN_NONE) begin
            state_d = ST_SLOT;
            cnt_d   = '0;
        end else if (state_q == ST_SLOT && cnt_q != CNT_LAST) begin
            cnt_d   = cnt_q + CNT_ONE;
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs: slot attributes latched at grant and held for the whole slot.
    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        ref_d   = ref_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ds_d    = ds_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        cs_d    = (state_q == ST_SLOT) && (cnt_q < CNT_CS_LAST);

        case (grant)
            OWN_REF: begin
                owner_d = OWN_REF;
                cs_d    = 1'b1;
                ref_d   = 1'b1;
                we_d    = 1'b0;
            end
            OWN_P0: begin
                owner_d = OWN_P0;
                cs_d    = 1'b1;
                ref_d   = 1'b0;
                we_d    = bus.p0_we;
                addr_d  = bus.p0_addr;
                din_d   = bus.p0_din;
                ds_d    = bus.p0_ds;
            end
            OWN_P1: begin
                owner_d = OWN_P1;
                cs_d    = 1'b1;
                ref_d   = 1'b0;
                we_d    = bus.p1_we;
                addr_d  = bus.p1_addr;
                din_d   = bus.p1_din;
                ds_d    = bus.p1_ds;
            end
            default: ;
        endcase

        if (state_q == ST_SLOT && cnt_q == CNT_CAPTURE) begin
            if (owner_q == OWN_P0) begin
                ack0_d = 1'b1;
                if (!we_q) dout0_d = bus.mem_dout;
            end else if (owner_q == OWN_P1) begin
                ack1_d = 1'b1;
                if (!we_q) dout1_d = bus.mem_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            ref_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ds_q    <= '1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            owner_q <= owner_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            ref_q   <= ref_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ds_q    <= ds_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    assign bus.mem_cs      = cs_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_refresh = ref_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_din     = din_q;
    assign bus.mem_ds      = ds_q;
    assign bus.p0_ack      = ack0_q;
    assign bus.p1_ack      = ack1_q;
    assign bus.p0_dout     = dout0_q;
    assign bus.p1_dout     = dout1_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus for sdram_arbiter with a slot-level
// behavioural model checked on every falling edge, plus literal expectations
// for latency, priority, refresh cadence, reset and mem_ready behaviour.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int unsigned RI = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic dout_mode = 1'b0;
    logic cmp_en = 1'b0;
    int unsigned cyc;
    int tests = 0;
    int fails = 0;

    sdram_arbiter_if bus ();

    sdram_arbiter #(.REFRESH_INTERVAL(RI)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: cyc == k after the k-th rising edge following reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Controller read data: constant, or a per-cycle pattern that pins the capture edge.
    assign bus.mem_dout = dout_mode ? {cyc[7:0], 8'h5A} : 16'hBEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy;
    int          m_phase;
    int          m_owner;
    int          m_tick;
    int          m_pend;
    logic        e_cs, e_we, e_ref, e_ack0, e_ack1;
    logic [21:0] e_addr;
    logic [15:0] e_din, e_dout0, e_dout1;
    logic [1:0]  e_ds;

    always @(posedge clk or negedge reset_n) begin : model
        int g;
        bit wrap;
        if (!reset_n) begin
            m_busy = 0; m_phase = 0; m_owner = -1; m_tick = 0; m_pend = 0;
            e_cs = 0; e_we = 0; e_ref = 0; e_ack0 = 0; e_ack1 = 0;
            e_addr = '0; e_din = '0; e_ds = 2'b11; e_dout0 = '0; e_dout1 = '0;
        end else begin
            g = -1;
            if (bus.mem_ready && (!m_busy || m_phase == SLOT_LEN - 1)) begin
                if (m_pend > 0)       g = 2;
                else if (bus.p0_req)  g = 0;
                else if (bus.p1_req)  g = 1;
            end
            e_ack0 = 0;
            e_ack1 = 0;
            if (m_busy && m_phase == 7) begin
                if (m_owner == 0) begin
                    e_ack0 = 1;
                    if (!e_we) e_dout0 = bus.mem_dout;
                end else if (m_owner == 1) begin
                    e_ack1 = 1;
                    if (!e_we) e_dout1 = bus.mem_dout;
                end
            end
            wrap   = (m_tick == RI - 1);
            m_tick = wrap ? 0 : m_tick + 1;
            m_pend = m_pend + (wrap ? 1 : 0) - (g == 2 ? 1 : 0);
            if (m_pend > 3) m_pend = 3;
            if (g >= 0) begin
                m_busy = 1; m_phase = 0; m_owner = g;
                if (g == 2) begin
                    e_ref = 1; e_we = 0;
                end else if (g == 0) begin
                    e_ref = 0; e_we = bus.p0_we; e_addr = bus.p0_addr; e_din = bus.p0_din; e_ds = bus.p0_ds;
                end else begin
                    e_ref = 0; e_we = bus.p1_we; e_addr = bus.p1_addr; e_din = bus.p1_din; e_ds = bus.p1_ds;
                end
            end else if (m_busy) begin
                m_phase++;
                if (m_phase == SLOT_LEN) m_busy = 0;
            end
            e_cs = m_busy && (m_phase <= 3);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_cs",      32'(bus.mem_cs),      32'(e_cs));
            chk("mem_we",      32'(bus.mem_we),      32'(e_we));
            chk("mem_refresh", 32'(bus.mem_refresh), 32'(e_ref));
            chk("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
            chk("mem_din",     32'(bus.mem_din),     32'(e_din));
            chk("mem_ds",      32'(bus.mem_ds),      32'(e_ds));
            chk("p0_ack",      32'(bus.p0_ack),      32'(e_ack0));
            chk("p1_ack",      32'(bus.p1_ack),      32'(e_ack1));
            chk("p0_dout",     32'(bus.p0_dout),     32'(e_dout0));
            chk("p1_dout",     32'(bus.p1_dout),     32'(e_dout1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.mem_ready = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_din = '0; bus.p0_ds = 2'b11;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_din = '0; bus.p1_ds = 2'b11;
    endtask

    // Returns at the falling edge right after release; the next rising edge is edge 1.
    task automatic reset_dut();
        @(negedge clk);
        #2 reset_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_cnt, ack_at, ack1_at, first_cs, rises, acks;
        logic prev_cs;
        idle_inputs();
        @(posedge clk);
        cmp_en = 1'b1;

        // T1: single p1 read, constant read data.
        reset_dut();
        dout_mode = 0;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 22'h12345;
        cs_cnt = 0; ack_at = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) chk("t1_addr", 32'(bus.mem_addr), 32'h12345);
            if (bus.mem_cs) cs_cnt++;
            if (bus.p1_ack && ack_at == 0) begin
                ack_at = i;
                chk("t1_dout", 32'(bus.p1_dout), 32'hBEEF);
                bus.p1_req = 0;
            end
        end
        chk("t1_cs_clocks", 32'(cs_cnt), 32'd4);
        chk("t1_ack_latency", 32'(ack_at), 32'd9);

        // T2: p0 write and p1 read raised together.
        reset_dut();
        dout_mode = 1;
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 22'h0AAAA; bus.p0_din = 16'h1234; bus.p0_ds = 2'b01;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 22'h3F0F0; bus.p1_ds = 2'b10;
        ack_at = 0; ack1_at = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("t2_p0_cs",  32'(bus.mem_cs),  32'd1);
                chk("t2_p0_we",  32'(bus.mem_we),  32'd1);
                chk("t2_p0_din", 32'(bus.mem_din), 32'h1234);
                chk("t2_p0_ds",  32'(bus.mem_ds),  32'h1);
            end
            if (i == 10) chk("t2_gap_cs", 32'(bus.mem_cs), 32'd0);
            if (i == 11) begin
                chk("t2_p1_cs",   32'(bus.mem_cs),   32'd1);
                chk("t2_p1_we",   32'(bus.mem_we),   32'd0);
                chk("t2_p1_addr", 32'(bus.mem_addr), 32'h3F0F0);
            end
            if (bus.p0_ack && ack_at == 0) begin ack_at = i; bus.p0_req = 0; end
            if (bus.p1_ack && ack1_at == 0) begin
                ack1_at = i;
                chk("t2_p1_dout", 32'(bus.p1_dout), 32'h125A);
                bus.p1_req = 0;
            end
        end
        chk("t2_p0_ack_at", 32'(ack_at), 32'd9);
        chk("t2_p1_ack_at", 32'(ack1_at), 32'd19);

        // T3: idle bus, refresh only.
        reset_dut();
        first_cs = 0; rises = 0; acks = 0; prev_cs = 0;
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk);
            if (bus.mem_cs && !prev_cs) begin
                rises++;
                if (first_cs == 0) first_cs = i;
                chk("t3_refresh_flag", 32'(bus.mem_refresh), 32'd1);
            end
            if (bus.p0_ack || bus.p1_ack) acks++;
            prev_cs = bus.mem_cs;
        end
        chk("t3_first_refresh", 32'(first_cs), 32'd21);
        chk("t3_refresh_count", 32'(rises), 32'd3);
        chk("t3_no_acks", 32'(acks), 32'd0);

        // T4: continuous p0 writes with a refresh becoming pending.
        reset_dut();
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 22'h15555; bus.p0_din = 16'hCAFE; bus.p0_ds = 2'b11;
        acks = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 21) begin
                chk("t4_ref_cs",   32'(bus.mem_cs),      32'd1);
                chk("t4_ref_flag", 32'(bus.mem_refresh), 32'd1);
                chk("t4_ref_we",   32'(bus.mem_we),      32'd0);
                chk("t4_ref_addr", 32'(bus.mem_addr),    32'h15555);
            end
            if (i == 31) begin
                chk("t4_p0_cs",   32'(bus.mem_cs),      32'd1);
                chk("t4_p0_flag", 32'(bus.mem_refresh), 32'd0);
                chk("t4_p0_we",   32'(bus.mem_we),      32'd1);
            end
            if (bus.p0_ack) acks++;
        end
        chk("t4_p0_acks", 32'(acks), 32'd3);
        bus.p0_req = 0;

        // T5: reset asserted at slot count 5 of a p1 read.
        reset_dut();
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 22'h00123;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_cs",    32'(bus.mem_cs),      32'd0);
        chk("t5_rst_we",    32'(bus.mem_we),      32'd0);
        chk("t5_rst_ref",   32'(bus.mem_refresh), 32'd0);
        chk("t5_rst_addr",  32'(bus.mem_addr),    32'd0);
        chk("t5_rst_din",   32'(bus.mem_din),     32'd0);
        chk("t5_rst_ds",    32'(bus.mem_ds),      32'd3);
        chk("t5_rst_ack1",  32'(bus.p1_ack),      32'd0);
        chk("t5_rst_dout0", 32'(bus.p0_dout),     32'd0);
        bus.p1_req = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 22'h2A2A2;
        ack_at = 0; acks = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("t5_clean_cs",   32'(bus.mem_cs),   32'd1);
                chk("t5_clean_addr", 32'(bus.mem_addr), 32'h2A2A2);
            end
            if (bus.p0_ack && ack_at == 0) begin ack_at = i; bus.p0_req = 0; end
            if (bus.p1_ack) acks++;
        end
        chk("t5_p0_ack_at", 32'(ack_at), 32'd9);
        chk("t5_no_p1_ack", 32'(acks), 32'd0);

        // T6: mem_ready low blocks the start; dropping it mid-slot blocks the next grant.
        reset_dut();
        bus.mem_ready = 0;
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 22'h01111; bus.p0_din = 16'h0F0F;
        cs_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.mem_cs) cs_cnt++;
        end
        chk("t6_blocked_cs", 32'(cs_cnt), 32'd0);
        bus.mem_ready = 1;
        @(negedge clk);
        chk("t6_start_cs", 32'(bus.mem_cs), 32'd1);
        chk("t6_start_we", 32'(bus.mem_we), 32'd1);
        cs_cnt = 0; ack_at = 0;
        for (int i = 12; i <= 30; i++) begin
            @(negedge clk);
            if (i == 13) bus.mem_ready = 0;
            if (bus.mem_cs) cs_cnt++;
            if (bus.p0_ack && ack_at == 0) ack_at = i;
        end
        chk("t6_cs_rest", 32'(cs_cnt), 32'd3);
        chk("t6_ack_at", 32'(ack_at), 32'd19);
        bus.p0_req = 0;
        bus.mem_ready = 1;
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
